// File: rtl/host_reg_bank.sv
// Host-bus register bank: ID/CTRL/STATUS/SCRATCH/counter registers and a byte FIFO
// behind a 4-bit address, 8-bit data single-cycle host bus.
module host_reg_bank #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sel_i,
    input  logic       wr_i,
    input  logic [3:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic [7:0] ctrl_o,
    output logic       irq_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [3:0] {
        A_ID      = 4'h0,
        A_CTRL    = 4'h1,
        A_STATUS  = 4'h2,
        A_FIFO_WR = 4'h3,
        A_FIFO_RD = 4'h4,
        A_LEVEL   = 4'h5,
        A_SCRATCH = 4'h6,
        A_WR_CNT  = 4'h7,
        A_ERR_CNT = 4'h8
    } addr_e;

    logic [7:0]    ctrl_q, ctrl_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic [7:0]    scratch_q, scratch_d;
    logic [7:0]    wr_cnt_q, wr_cnt_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          irq_q;
    logic          push;
    logic [7:0]    mem_q [DEPTH];

    logic rd_acc, wr_acc, empty, full;

    assign rd_acc = sel_i & ~wr_i;
    assign wr_acc = sel_i & wr_i;
    assign empty  = (level_q == '0);
    assign full   = (level_q == (AW+1)'(DEPTH));

    always_comb begin
        ctrl_d    = ctrl_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        scratch_d = scratch_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        rdata_d   = rdata_q;
        push      = 1'b0;

        if (wr_acc && wr_cnt_q != 8'hFF) begin
            wr_cnt_d = wr_cnt_q + 8'd1;
        end
        if (sel_i && addr_i >= 4'h9 && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        if (wr_acc) begin
            case (addr_i)
                A_CTRL: begin
                    ctrl_d = wdata_i;
                    if (!wdata_i[0]) begin
                        wptr_d  = '0;
                        rptr_d  = '0;
                        level_d = '0;
                    end
                end
                A_STATUS: begin
                    if (wdata_i[2]) ovf_d = 1'b0;
                    if (wdata_i[3]) udf_d = 1'b0;
                end
                A_FIFO_WR: begin
                    if (ctrl_q[0]) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            push    = 1'b1;
                            wptr_d  = wptr_q + AW'(1);
                            level_d = level_q + (AW+1)'(1);
                        end
                    end
                end
                A_SCRATCH: scratch_d = wdata_i;
                default: ;
            endcase
        end

        // Every read reloads rdata; unmapped or write-only addresses read as zero.
        if (rd_acc) begin
            rdata_d = '0;
            case (addr_i)
                A_ID:      rdata_d = ID_VALUE;
                A_CTRL:    rdata_d = ctrl_q;
                A_STATUS:  rdata_d = {4'b0, udf_q, ovf_q, full, empty};
                A_FIFO_RD: begin
                    if (ctrl_q[0]) begin
                        if (empty) begin
                            udf_d = 1'b1;
                        end else begin
                            rdata_d = mem_q[rptr_q];
                            rptr_d  = rptr_q + AW'(1);
                            level_d = level_q - (AW+1)'(1);
                        end
                    end
                end
                A_LEVEL:   rdata_d = 8'(level_q);
                A_SCRATCH: rdata_d = scratch_q;
                A_WR_CNT:  rdata_d = wr_cnt_q;
                A_ERR_CNT: rdata_d = err_cnt_q;
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_q    <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            scratch_q <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            scratch_q <= scratch_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            rdata_q   <= rdata_d;
            irq_q     <= ctrl_q[1] & (ovf_q | udf_q);
        end
    end

    // Storage needs no reset; occupancy is tracked by level/pointers alone.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;
    assign ctrl_o  = ctrl_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_host_reg_bank.sv
// Scoreboard bench for host_reg_bank: reads queue expected data, a monitor
// compares rdata_o just after each edge that captured a read.
module tb_host_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       wr = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic [7:0] ctrl;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    logic [3:0] tag_q [$];

    host_reg_bank #(.DEPTH(8), .ID_VALUE(8'hA5)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sel_i  (sel),
        .wr_i   (wr),
        .addr_i (addr),
        .wdata_i(wdata),
        .rdata_o(rdata),
        .ctrl_o (ctrl),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    // Monitor: inputs change only on negedge, so they still describe the access just captured.
    always @(posedge clk) begin
        #1;
        if (rst_n && sel && !wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected addr=%h got=%h want=<none queued>", addr, rdata);
            end else begin
                logic [7:0] e;
                logic [3:0] t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL rd_addr_%h got=%h want=%h", t, rdata, e);
                end
            end
        end
    end

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [7:0] e);
        @(negedge clk);
        sel = 1'b1; wr = 1'b0; addr = a; wdata = '0;
        exp_q.push_back(e);
        tag_q.push_back(a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sel = 1'b0; wr = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and power-on values
        rst_n = 1'b0;
        idle(2);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_ctrl", ctrl, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);
        rst_n = 1'b1;
        rd_reg(4'h0, 8'hA5);
        rd_reg(4'h2, 8'h01);
        rd_reg(4'h5, 8'h00);
        rd_reg(4'h3, 8'h00);

        // Basic FIFO order
        wr_reg(4'h1, 8'h03);
        wr_reg(4'h3, 8'h11);
        wr_reg(4'h3, 8'h22);
        wr_reg(4'h3, 8'h33);
        idle(1);
        chk("ctrl_after_write", ctrl, 8'h03);
        rd_reg(4'h5, 8'h03);
        rd_reg(4'h4, 8'h11);
        rd_reg(4'h4, 8'h22);
        rd_reg(4'h4, 8'h33);
        rd_reg(4'h5, 8'h00);

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) wr_reg(4'h3, 8'h40 + 8'(i));
        rd_reg(4'h2, 8'h06);
        rd_reg(4'h5, 8'h08);
        idle(2);
        chk("irq_on_ovf", {7'b0, irq}, 8'h01);
        wr_reg(4'h2, 8'h04);
        rd_reg(4'h2, 8'h02);
        idle(2);
        chk("irq_after_w1c", {7'b0, irq}, 8'h00);

        // Drain, then underflow
        for (int i = 0; i < 8; i++) rd_reg(4'h4, 8'h40 + 8'(i));
        rd_reg(4'h4, 8'h00);
        rd_reg(4'h2, 8'h09);
        idle(2);
        chk("irq_on_udf", {7'b0, irq}, 8'h01);
        wr_reg(4'h2, 8'h08);
        rd_reg(4'h2, 8'h01);

        // FIFO disabled: no udf, pushes dropped
        wr_reg(4'h1, 8'h02);
        rd_reg(4'h4, 8'h00);
        rd_reg(4'h2, 8'h01);
        wr_reg(4'h3, 8'h55);
        rd_reg(4'h5, 8'h00);
        rd_reg(4'h1, 8'h02);

        // Write counter saturation and scratch
        for (int i = 0; i < 300; i++) wr_reg(4'h6, 8'(i));
        rd_reg(4'h7, 8'hFF);
        rd_reg(4'h6, 8'h2B);

        // Unmapped accesses
        rd_reg(4'hC, 8'h00);
        wr_reg(4'hC, 8'h77);
        rd_reg(4'h8, 8'h02);
        rd_reg(4'hC, 8'h00);
        rd_reg(4'h8, 8'h03);

        // Reset in the middle of a push sequence
        wr_reg(4'h6, 8'h5A);
        wr_reg(4'h1, 8'h03);
        wr_reg(4'h3, 8'hA1);
        wr_reg(4'h3, 8'hA2);
        wr_reg(4'h3, 8'hA3);
        @(negedge clk);
        rst_n = 1'b0;
        wdata = 8'hA4;
        @(negedge clk);
        rst_n = 1'b1;
        sel = 1'b0;
        chk("midreset_ctrl", ctrl, 8'h00);
        rd_reg(4'h5, 8'h00);
        rd_reg(4'h2, 8'h01);
        rd_reg(4'h6, 8'h00);
        rd_reg(4'h7, 8'h00);
        idle(3);

        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
